// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA raster timing generator and pixel output stage.
//
// A horizontal/vertical counter pair walks the raster one position per enabled
// clock. Coordinates and a pixel request go to the frame source combinationally
// (stage 0). The raw hs/vs/de/sof/sol flags travel through a PIX_LAT-deep delay
// line, so they meet the colour that the source returns PIX_LAT enabled cycles
// later. A final output register then drives the DAC.
//
// Optional build macro: TEST_PATTERN_EN adds input tp_sel, which replaces the
// colour input with eight vertical colour bars.
//
// Ports:
//   clk_25M      pixel/system clock
//   rst          synchronous reset, active-high, overrides pix_en
//   pix_en       pixel-rate clock enable; all state holds while low
//   color        {R,G,B} from the frame source, valid PIX_LAT enabled cycles after pix_req
//   tp_sel       (TEST_PATTERN_EN only) selects the colour-bar pattern
//   hcnt_out     current horizontal count (stage 0)
//   vcnt_out     current vertical count (stage 0)
//   pix_req      stage-0 coordinates lie in the active area
//   hsync/vsync  registered syncs at the configured polarity, aligned with vga_rgb
//   vga_de       registered data enable
//   vga_rgb      registered {R,G,B}; zero outside the active area
//   frame_start  one-enabled-cycle pulse with the first active pixel of a frame
//   line_start   one-enabled-cycle pulse with the first pixel of every line
//   frame_cnt    completed-frame count, wraps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 1,
  parameter int PIX_LAT  = 1,
  parameter int CNT_W    = 12,
  parameter int FRAME_W  = 8
) (
  input  logic                   clk_25M,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [3*COLOR_W-1:0]   color,
`ifdef TEST_PATTERN_EN
  input  logic                   tp_sel,
`endif
  output logic [CNT_W-1:0]       hcnt_out,
  output logic [CNT_W-1:0]       vcnt_out,
  output logic                   pix_req,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   vga_de,
  output logic [3*COLOR_W-1:0]   vga_rgb,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [FRAME_W-1:0]     frame_cnt
);

  localparam int RGB_W   = 3*COLOR_W;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic             HS_LVL   = (HS_POL != 0);
  localparam logic             VS_LVL   = (VS_POL != 0);

  // Everything that must stay aligned with the returning pixel colour.
  // The all-zero value is the inactive state.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic sof;
    logic sol;
`ifdef TEST_PATTERN_EN
    logic             tp;
    logic [RGB_W-1:0] bar;
`endif
  } pipe_t;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pix_en) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // ---------------------------------------------------------------- stage 0
  pipe_t raw;

  assign hcnt_out = hcnt_q;
  assign vcnt_out = vcnt_q;
  assign pix_req  = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);

`ifdef TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);
  logic [CNT_W-1:0] bar_idx;
  logic [2:0]       bar_b;

  // Integer bar width may leave a remainder on the right; clamp into bar 7.
  always_comb begin
    bar_idx = hcnt_q / BAR_W_C;
    bar_b   = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
  end
`endif

  always_comb begin
    raw     = '0;
    raw.hs  = (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
    // Vertical sync looks at vcnt only, so its edges land on hcnt == 0.
    raw.vs  = (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
    raw.de  = pix_req;
    raw.sof = (hcnt_q == '0) && (vcnt_q == '0);
    raw.sol = (hcnt_q == '0);
`ifdef TEST_PATTERN_EN
    raw.tp  = tp_sel;
    raw.bar = {{COLOR_W{bar_b[2]}}, {COLOR_W{bar_b[1]}}, {COLOR_W{bar_b[0]}}};
`endif
  end

  // ---------------------------------------------------------------- delay line
  pipe_t dly;

  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      pipe_t pipe_q [PIX_LAT];

      always_ff @(posedge clk_25M) begin
        if (rst) begin
          for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
        end else if (pix_en) begin
          pipe_q[0] <= raw;
          for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign dly = pipe_q[PIX_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------- output register
  logic               hs_q, vs_q, de_q, fs_q, ls_q;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic [FRAME_W-1:0] fcnt_q;

  always_comb begin
    rgb_d = '0;
    if (dly.de) begin
`ifdef TEST_PATTERN_EN
      rgb_d = dly.tp ? dly.bar : color;
`else
      rgb_d = color;
`endif
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
      fcnt_q <= '0;
    end else if (pix_en) begin
      hs_q  <= dly.hs;
      vs_q  <= dly.vs;
      de_q  <= dly.de;
      rgb_q <= rgb_d;
      fs_q  <= dly.sof;
      ls_q  <= dly.sol;
      // Count on the same edge that raises frame_start.
      if (dly.sof) fcnt_q <= fcnt_q + FRAME_W'(1);
    end
  end

  assign hsync       = hs_q ~^ HS_LVL;
  assign vsync       = vs_q ~^ VS_LVL;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Small raster so several whole frames fit in a short run.
  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VSW = 2, VB = 2;
  localparam int HP = 0, VP = 1;
  localparam int CW = 2, L = 2, CNTW = 8, FW = 2;
  localparam int RGBW = 3*CW;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            pix_en = 1'b0;
  logic [RGBW-1:0] color = '0;
  logic            tp_sel = 1'b0;

  logic [CNTW-1:0] hcnt_out, vcnt_out;
  logic            pix_req, hsync, vsync, vga_de, frame_start, line_start;
  logic [RGBW-1:0] vga_rgb;
  logic [FW-1:0]   frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(HP), .VS_POL(VP), .COLOR_W(CW), .PIX_LAT(L),
    .CNT_W(CNTW), .FRAME_W(FW)
  ) dut (
    .clk_25M(clk), .rst(rst), .pix_en(pix_en), .color(color),
`ifdef TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .hcnt_out(hcnt_out), .vcnt_out(vcnt_out), .pix_req(pix_req),
    .hsync(hsync), .vsync(vsync), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .line_start(line_start), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: k = enabled edges since reset release; last_col = colour
  // presented at the most recent enabled edge.
  int              k = 0;
  logic [RGBW-1:0] last_col = '0;

  typedef struct {
    logic [CNTW-1:0] hcnt;
    logic [CNTW-1:0] vcnt;
    logic            pix_req;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [RGBW-1:0] rgb;
    logic            fs;
    logic            ls;
    logic [FW-1:0]   fcnt;
  } exp_t;

  // Raster position kk is the stage-0 position; outputs show position kk-1-L.
  function automatic exp_t model(int kk);
    exp_t e;
    int m, h, v, b;
    e.hcnt    = CNTW'(kk % HT);
    e.vcnt    = CNTW'((kk / HT) % VT);
    e.pix_req = ((kk % HT) < HA) && (((kk / HT) % VT) < VA);
    e.hsync   = (HP == 0);
    e.vsync   = (VP == 0);
    e.de      = 1'b0;
    e.rgb     = '0;
    e.fs      = 1'b0;
    e.ls      = 1'b0;
    e.fcnt    = '0;
    m = kk - 1 - L;
    if (m >= 0) begin
      h = m % HT;
      v = (m / HT) % VT;
      if (h >= HA + HF && h < HA + HF + HSW) e.hsync = (HP != 0);
      if (v >= VA + VF && v < VA + VF + VSW) e.vsync = (VP != 0);
      e.de   = (h < HA) && (v < VA);
      e.fs   = (m % FT == 0);
      e.ls   = (h == 0);
      e.fcnt = FW'((m / FT + 1) % (1 << FW));
      if (e.de) begin
        if (tp_sel) begin
          b = h / (HA / 8);
          if (b > 7) b = 7;
          e.rgb = {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
        end else begin
          e.rgb = last_col;
        end
      end
    end
    return e;
  endfunction

  // Drive one clock with the given inputs, advance the model, land on negedge.
  task automatic step(input logic en, input logic r);
    pix_en = en;
    rst    = r;
    color  = RGBW'($urandom);
    @(posedge clk);
    if (r) k = 0;
    else if (en) begin
      k++;
      last_col = color;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    exp_t e;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    e = model(k);
    checks++; if (hcnt_out !== e.hcnt) begin errors++; $display("FAIL reset.hcnt got %0d want %0d", hcnt_out, e.hcnt); end
    checks++; if (vcnt_out !== e.vcnt) begin errors++; $display("FAIL reset.vcnt got %0d want %0d", vcnt_out, e.vcnt); end
    checks++; if (hsync !== e.hsync) begin errors++; $display("FAIL reset.hsync got %b want %b", hsync, e.hsync); end
    checks++; if (vsync !== e.vsync) begin errors++; $display("FAIL reset.vsync got %b want %b", vsync, e.vsync); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL reset.de got %b want 0", vga_de); end
    checks++; if (vga_rgb !== '0) begin errors++; $display("FAIL reset.rgb got %h want 0", vga_rgb); end
    checks++; if (frame_start !== 1'b0 || line_start !== 1'b0) begin errors++; $display("FAIL reset.pulses got fs=%b ls=%b want 0 0", frame_start, line_start); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset.fcnt got %0d want 0", frame_cnt); end
  endtask

  task automatic test_raster;
    exp_t e;
    int nfs = 0, nls = 0;
    repeat (2*FT) begin
      step(1'b1, 1'b0);
      e = model(k);
      checks++; if (hcnt_out !== e.hcnt || vcnt_out !== e.vcnt) begin errors++; $display("FAIL raster.cnt k=%0d got %0d,%0d want %0d,%0d", k, hcnt_out, vcnt_out, e.hcnt, e.vcnt); end
      checks++; if (pix_req !== e.pix_req) begin errors++; $display("FAIL raster.pix_req k=%0d got %b want %b", k, pix_req, e.pix_req); end
      checks++; if (frame_start !== e.fs) begin errors++; $display("FAIL raster.frame_start k=%0d got %b want %b", k, frame_start, e.fs); end
      checks++; if (line_start !== e.ls) begin errors++; $display("FAIL raster.line_start k=%0d got %b want %b", k, line_start, e.ls); end
      checks++; if (frame_cnt !== e.fcnt) begin errors++; $display("FAIL raster.fcnt k=%0d got %0d want %0d", k, frame_cnt, e.fcnt); end
      if (frame_start === 1'b1) nfs++;
      if (line_start === 1'b1) nls++;
    end
    checks++; if (nfs != 2) begin errors++; $display("FAIL raster.nframes got %0d want 2", nfs); end
    checks++; if (nls != 2*VT) begin errors++; $display("FAIL raster.nlines got %0d want %0d", nls, 2*VT); end
  endtask

  task automatic test_sync;
    exp_t e;
    repeat (FT) begin
      step(1'b1, 1'b0);
      e = model(k);
      checks++; if (hsync !== e.hsync) begin errors++; $display("FAIL sync.hsync k=%0d got %b want %b", k, hsync, e.hsync); end
      checks++; if (vsync !== e.vsync) begin errors++; $display("FAIL sync.vsync k=%0d got %b want %b", k, vsync, e.vsync); end
      checks++; if (vga_de !== e.de) begin errors++; $display("FAIL sync.de k=%0d got %b want %b", k, vga_de, e.de); end
    end
  endtask

  task automatic test_color;
    exp_t e;
    repeat (FT) begin
      step(1'b1, 1'b0);
      e = model(k);
      checks++; if (vga_rgb !== e.rgb) begin errors++; $display("FAIL color.rgb k=%0d got %h want %h", k, vga_rgb, e.rgb); end
      checks++; if (vga_de !== e.de) begin errors++; $display("FAIL color.de k=%0d got %b want %b", k, vga_de, e.de); end
    end
  endtask

  task automatic test_pix_en;
    exp_t e;
    repeat (1500) begin
      step(1'($urandom % 2), 1'b0);
      e = model(k);
      checks++; if (hcnt_out !== e.hcnt || vcnt_out !== e.vcnt) begin errors++; $display("FAIL pix_en.cnt k=%0d got %0d,%0d want %0d,%0d", k, hcnt_out, vcnt_out, e.hcnt, e.vcnt); end
      checks++; if (frame_start !== e.fs || line_start !== e.ls) begin errors++; $display("FAIL pix_en.pulses k=%0d got %b%b want %b%b", k, frame_start, line_start, e.fs, e.ls); end
      checks++; if (hsync !== e.hsync || vsync !== e.vsync) begin errors++; $display("FAIL pix_en.sync k=%0d got %b%b want %b%b", k, hsync, vsync, e.hsync, e.vsync); end
      checks++; if (vga_rgb !== e.rgb) begin errors++; $display("FAIL pix_en.rgb k=%0d got %h want %h", k, vga_rgb, e.rgb); end
      checks++; if (frame_cnt !== e.fcnt) begin errors++; $display("FAIL pix_en.fcnt k=%0d got %0d want %0d", k, frame_cnt, e.fcnt); end
    end
  endtask

  task automatic test_frame_wrap;
    exp_t e;
    repeat (4*FT + 3) begin
      step(1'b1, 1'b0);
      e = model(k);
      checks++; if (frame_cnt !== e.fcnt) begin errors++; $display("FAIL wrap.fcnt k=%0d got %0d want %0d", k, frame_cnt, e.fcnt); end
    end
  endtask

  task automatic test_midline_reset;
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(30, 200)) step(1'b1, 1'b0);
      step(1'($urandom % 2), 1'b1);
      e = model(k);
      checks++; if (hcnt_out !== e.hcnt || vcnt_out !== e.vcnt) begin errors++; $display("FAIL midrst.cnt got %0d,%0d want %0d,%0d", hcnt_out, vcnt_out, e.hcnt, e.vcnt); end
      checks++; if (vga_de !== 1'b0 || vga_rgb !== '0) begin errors++; $display("FAIL midrst.de_rgb got %b %h want 0 0", vga_de, vga_rgb); end
      checks++; if (hsync !== e.hsync || vsync !== e.vsync) begin errors++; $display("FAIL midrst.sync got %b%b want %b%b", hsync, vsync, e.hsync, e.vsync); end
      checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL midrst.fcnt got %0d want 0", frame_cnt); end
      repeat (L + 3) begin
        step(1'b1, 1'b0);
        e = model(k);
        checks++; if (frame_start !== e.fs || frame_cnt !== e.fcnt) begin errors++; $display("FAIL midrst.first_frame k=%0d got fs=%b fcnt=%0d want fs=%b fcnt=%0d", k, frame_start, frame_cnt, e.fs, e.fcnt); end
        checks++; if (vga_de !== e.de) begin errors++; $display("FAIL midrst.de k=%0d got %b want %b", k, vga_de, e.de); end
      end
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern;
    exp_t e;
    tp_sel = 1'b1;
    step(1'b1, 1'b1);
    repeat (FT + L + 2) begin
      step(1'b1, 1'b0);
      e = model(k);
      checks++; if (vga_rgb !== e.rgb) begin errors++; $display("FAIL pattern.rgb k=%0d got %h want %h", k, vga_rgb, e.rgb); end
    end
    tp_sel = 1'b0;
    step(1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_raster();
    test_sync();
    test_color();
    test_pix_en();
    test_frame_wrap();
    test_midline_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    test_color();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
